ram_write_arb: RTL and testbench
================================

Name: ram_write_arb

Overview:
- Per-RAM write arbiter that sits directly downstream of the write-command selector.
- One instance per data RAM (8 per hash group). It receives that RAM's west/east/south/north write-command slots, buffers each direction in a small FIFO, and round-robin arbitrates onto the single RAM write port.
- Read has priority on the RAM port. Each FIFO pop returns a credit upstream, because the selector path has no ready backpressure.

Parameters:
- DEPTH, 4, entries per direction FIFO; power of two, min 2.
- NDIR, 4, number of directions; fixed at 4 (0=west, 1=east, 2=south, 3=north).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  [3:0]  per-direction write command valid for this RAM.
- in_pld  input  write_ram_pld_t [3:0]  per-direction write payload, from vector_cache_pkg.
- ram_rd_busy  input  1  RAM port taken by a read this cycle; blocks write grant.
- ram_wr_vld  output  1  registered write strobe to the RAM wrapper.
- ram_wr_pld  output  write_ram_pld_t  registered write payload.
- ram_wr_src  output  [1:0]  direction index of the issued write.
- credit_rtn  output  [3:0]  one-cycle pulse per direction when its FIFO entry is popped.
- fifo_ovf_err  output  [3:0]  sticky: a write was dropped on a full FIFO.
- idle  output  1  all FIFOs empty and ram_wr_vld=0.

Behaviour:
- Reset values:
  - All FIFO pointers and counts = 0; RR pointer = 0.
  - ram_wr_vld=0, ram_wr_pld='0, ram_wr_src=0, credit_rtn=0, fifo_ovf_err=0, idle=1.
  - Reset asserted mid-operation flushes all queued writes with no credit pulses. A write in the output register is dropped; ram_wr_vld=0 in the cycle after rst is sampled.
- Enqueue:
  - in_vld[i]=1 and FIFO i not full → write at wptr; wptr += 1 mod DEPTH.
  - Full and a same-cycle pop of FIFO i → accepted.
  - Full and no pop → payload dropped and fifo_ovf_err[i] set. It stays set until rst.
- Count arithmetic:
  - Width $clog2(DEPTH+1).
  - Simultaneous push+pop leaves the count unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Arbitration (state: rr_ptr[1:0]):
  - Candidates = FIFOs with registered count != 0. There is no same-cycle bypass: an entry pushed in cycle N is eligible in N+1.
  - If ram_rd_busy=1 → no grant; rr_ptr holds.
  - Otherwise grant the first non-empty index scanning rr_ptr, rr_ptr+1, … mod 4. On grant g: pop FIFO g, credit_rtn[g]=1 in the same cycle, rr_ptr ← (g+1) mod 4.
  - No candidates → rr_ptr holds.
- Output stage:
  - ram_wr_vld/pld/src registered from the grant.
  - Latency from in_vld to ram_wr_vld is 2 cycles minimum: push in N, grant in N+1, strobe in N+2.
  - At most one write strobe per cycle; back-to-back strobes are allowed. With no grant, ram_wr_vld=0 and the payload holds its previous value.
- Throughput: 1 write/cycle when ram_rd_busy=0. Starvation-free; worst-case wait is 3 grants per direction.
- idle is combinational: all counts zero and ram_wr_vld=0.
- The payload passes through unmodified. dest_ram_id routing is already resolved upstream and is not checked here.

Optional Feature:
- Macro RAM_WR_ARB_PERF_EN.
- Defined:
  - Adds output perf_blk_cnt [31:0]: cycles where any FIFO is non-empty and ram_rd_busy=1.
  - Adds output perf_wr_cnt [31:0]: issued writes.
  - Both saturate at all-ones and reset to 0 on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single write: rst released; in_vld=4'b0100 (south) for 1 cycle in cycle 5 → ram_wr_vld=1 in cycle 7, ram_wr_src=2, payload equal to input; credit_rtn=4'b0100 in cycle 6; idle=1 from cycle 8.
- Round-robin: all four FIFOs hold 2 entries, ram_rd_busy=0 → ram_wr_src sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles; then idle=1.
- Read blocking: 3 entries queued in west, ram_rd_busy=1 for 4 cycles → no ram_wr_vld and no credit during the block; 3 back-to-back writes once busy drops; rr_ptr unchanged by the block.
- Overflow: DEPTH=4, ram_rd_busy=1, 5 west pushes → fifo_ovf_err=4'b0001 after the 5th; only the first 4 payloads are written after release. Variant: 5th push coincides with a pop → no error.
- Reset mid-operation: 3 entries per FIFO, assert rst for 1 cycle during a grant → ram_wr_vld=0 the next cycle, all counts 0, no further writes, credit_rtn stays 0.
- Perf (RAM_WR_ARB_PERF_EN): the read-blocking scenario gives perf_blk_cnt=4 and perf_wr_cnt=3.

Source files
------------

// File: rtl/ram_write_arb.sv
// ram_write_arb: four per-direction write FIFOs round-robin arbitrated onto one RAM write port.
// Optional macro RAM_WR_ARB_PERF_EN adds saturating blocked-cycle and issued-write counters.
package vector_cache_pkg;
    typedef struct packed {
        logic [2:0]  dest_ram_id;
        logic [7:0]  addr;
        logic [31:0] data;
    } write_ram_pld_t;
endpackage

module ram_write_arb
    import vector_cache_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NDIR  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NDIR-1:0]           in_vld,
    input  write_ram_pld_t [NDIR-1:0] in_pld,
    input  logic                      ram_rd_busy,
    output logic                      ram_wr_vld,
    output write_ram_pld_t            ram_wr_pld,
    output logic [1:0]                ram_wr_src,
    output logic [NDIR-1:0]           credit_rtn,
    output logic [NDIR-1:0]           fifo_ovf_err,
    output logic                      idle
`ifdef RAM_WR_ARB_PERF_EN
    ,
    output logic [31:0]               perf_blk_cnt,
    output logic [31:0]               perf_wr_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    write_ram_pld_t  mem  [NDIR][DEPTH];
    logic [PW-1:0]   wptr [NDIR];
    logic [PW-1:0]   rptr [NDIR];
    logic [CW-1:0]   cnt  [NDIR];
    logic [1:0]      rr_ptr;

    logic [NDIR-1:0] nonempty;
    logic [NDIR-1:0] full;
    logic [NDIR-1:0] pop;
    logic [NDIR-1:0] push;
    logic [NDIR-1:0] ovf;
    logic            grant_vld;
    logic [1:0]      grant_idx;

    // Upstream has no ready: in_vld is a fire-and-forget push, and each pop
    // returns one credit_rtn pulse so the sender can track free slots.
    always_comb begin
        for (int i = 0; i < NDIR; i++) begin
            nonempty[i] = (cnt[i] != '0);
            full[i]     = (cnt[i] == CW'(DEPTH));
        end
    end

    // Scan from the farthest offset down so the nearest non-empty index after rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        idx       = '0;
        if (!rst && !ram_rd_busy) begin
            for (int k = NDIR - 1; k >= 0; k--) begin
                idx = rr_ptr + 2'(k);
                if (nonempty[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_vld) pop[grant_idx] = 1'b1;
        for (int i = 0; i < NDIR; i++) begin
            push[i] = in_vld[i] && (!full[i] || pop[i]);
            ovf[i]  = in_vld[i] && full[i] && !pop[i];
        end
    end

    assign credit_rtn = pop;
    assign idle       = ~|nonempty && !ram_wr_vld;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NDIR; i++) begin
            if (!rst && push[i]) mem[i][wptr[i]] <= in_pld[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIR; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            rr_ptr       <= '0;
            ram_wr_vld   <= 1'b0;
            ram_wr_pld   <= '0;
            ram_wr_src   <= '0;
            fifo_ovf_err <= '0;
        end else begin
            for (int i = 0; i < NDIR; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
                if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
            end
            fifo_ovf_err <= fifo_ovf_err | ovf;
            ram_wr_vld   <= grant_vld;
            if (grant_vld) begin
                ram_wr_pld <= mem[grant_idx][rptr[grant_idx]];
                ram_wr_src <= grant_idx;
                rr_ptr     <= grant_idx + 2'd1;
            end
        end
    end

`ifdef RAM_WR_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_blk_cnt <= '0;
            perf_wr_cnt  <= '0;
        end else begin
            if ((|nonempty) && ram_rd_busy && (perf_blk_cnt != '1))
                perf_blk_cnt <= perf_blk_cnt + 32'd1;
            if (grant_vld && (perf_wr_cnt != '1))
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_write_arb.sv
// Randomized and directed bench for ram_write_arb against a queue-based reference model.
module tb_ram_write_arb;
  import vector_cache_pkg::*;

  localparam int DEPTH = 4;
  localparam int W = $bits(write_ram_pld_t) + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           in_vld;
  write_ram_pld_t [3:0] in_pld;
  logic                 ram_rd_busy;
  logic                 ram_wr_vld;
  write_ram_pld_t       ram_wr_pld;
  logic [1:0]           ram_wr_src;
  logic [3:0]           credit_rtn;
  logic [3:0]           fifo_ovf_err;
  logic                 idle;
`ifdef RAM_WR_ARB_PERF_EN
  logic [31:0]          perf_blk_cnt;
  logic [31:0]          perf_wr_cnt;
`endif

  ram_write_arb #(.DEPTH(DEPTH), .NDIR(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_pld(in_pld),
    .ram_rd_busy(ram_rd_busy),
    .ram_wr_vld(ram_wr_vld),
    .ram_wr_pld(ram_wr_pld),
    .ram_wr_src(ram_wr_src),
    .credit_rtn(credit_rtn),
    .fifo_ovf_err(fifo_ovf_err),
    .idle(idle)
`ifdef RAM_WR_ARB_PERF_EN
    ,
    .perf_blk_cnt(perf_blk_cnt),
    .perf_wr_cnt(perf_wr_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: one queue per direction, round-robin pointer, expected output register
  write_ram_pld_t q [4][$];
  int             rr;
  logic           exp_vld;
  write_ram_pld_t exp_pld;
  logic [1:0]     exp_src;
  logic [3:0]     exp_ovf;
  longint         exp_blk;
  longint         exp_wr;
  logic [W-1:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    rr = 0;
    exp_vld = 1'b0;
    exp_pld = '0;
    exp_src = '0;
    exp_ovf = '0;
    exp_blk = 0;
    exp_wr = 0;
    exp_q.delete();
  endtask

  function automatic int model_grant();
    if (rst || ram_rd_busy) return -1;
    for (int k = 0; k < 4; k++) begin
      if (q[(rr + k) % 4].size() > 0) return (rr + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < 4; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    if (!model_empty() && ram_rd_busy) exp_blk++;
    g = model_grant();
    if (g >= 0) begin
      exp_pld = q[g].pop_front();
      exp_src = 2'(g);
      exp_vld = 1'b1;
      rr = (g + 1) % 4;
      exp_wr++;
      exp_q.push_back({exp_src, exp_pld});
    end else begin
      exp_vld = 1'b0;
    end
    // pushes see the queue after this cycle's pop, so a full FIFO popped now still accepts
    for (int i = 0; i < 4; i++) begin
      if (in_vld[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(in_pld[i]);
        else exp_ovf[i] = 1'b1;
      end
    end
  endtask

  // driver: one clock cycle of stimulus, checks away from the active edge, then model update
  task automatic cycle(input logic [3:0] v, input logic b, input logic r);
    int g;
    @(negedge clk);
    in_vld = v;
    ram_rd_busy = b;
    rst = r;
    for (int i = 0; i < 4; i++) begin
      in_pld[i].dest_ram_id = 3'($urandom);
      in_pld[i].addr = 8'($urandom);
      in_pld[i].data = $urandom;
    end
    #1;
    g = model_grant();
    check("credit_rtn", 64'(credit_rtn), (g >= 0) ? 64'(1 << g) : 64'd0);
    check("idle", 64'(idle), 64'(model_empty() && !exp_vld));
    check("ram_wr_vld", 64'(ram_wr_vld), 64'(exp_vld));
    check("ram_wr_pld", 64'(ram_wr_pld), 64'(exp_pld));
    if (exp_vld) check("ram_wr_src", 64'(ram_wr_src), 64'(exp_src));
    check("fifo_ovf_err", 64'(fifo_ovf_err), 64'(exp_ovf));
    if (ram_wr_vld === 1'b1) begin
      check("sb_pending", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) check("sb_write", 64'({ram_wr_src, ram_wr_pld}), 64'(exp_q.pop_front()));
    end
`ifdef RAM_WR_ARB_PERF_EN
    check("perf_blk_cnt", 64'(perf_blk_cnt), 64'(exp_blk));
    check("perf_wr_cnt", 64'(perf_wr_cnt), 64'(exp_wr));
`endif
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    in_vld = '0;
    ram_rd_busy = 1'b0;
    in_pld = '0;
    repeat (2) @(posedge clk);
    model_reset();
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (3) cycle(4'b0000, 1'b0, 1'b0);

    // single south write
    cycle(4'b0100, 1'b0, 1'b0);
    repeat (4) cycle(4'b0000, 1'b0, 1'b0);

    // round-robin: two entries in every FIFO, then drain
    repeat (2) cycle(4'b1111, 1'b1, 1'b0);
    repeat (10) cycle(4'b0000, 1'b0, 1'b0);

    // read blocking: three west entries, busy for four cycles, then release
    repeat (3) cycle(4'b0001, 1'b1, 1'b0);
    repeat (4) cycle(4'b0000, 1'b1, 1'b0);
    repeat (5) cycle(4'b0000, 1'b0, 1'b0);

    // overflow variant: fifth push coincides with a pop
    repeat (4) cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    repeat (7) cycle(4'b0000, 1'b0, 1'b0);

    // overflow: five west pushes while blocked
    repeat (5) cycle(4'b0001, 1'b1, 1'b0);
    repeat (7) cycle(4'b0000, 1'b0, 1'b0);

    // reset mid-operation during a grant
    repeat (3) cycle(4'b1111, 1'b1, 1'b0);
    repeat (2) cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (4) cycle(4'b0000, 1'b0, 1'b0);

    // random: sparse then dense traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic [3:0] v;
      v = 4'($urandom);
      if (n < 300) v = v & 4'($urandom) & 4'($urandom);
      cycle(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end
    repeat (20) cycle(4'b0000, 1'b0, 1'b0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
